// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer: holds data-memory controls for MEM_LATENCY cycles per
// load/store, stalls the pipeline meanwhile and returns a one-cycle response.
module mem_access_ctrl #(
   parameter int MEM_LATENCY = 2,
   parameter int ADDR_WORDS  = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        misalign,
   output logic        oob,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2,
      ERR    = 2'd3
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

   state_t     state;
   logic [3:0] count;
   logic       req_any;
   logic       req_mis;
   logic       req_oob;
   logic       req_ok;

   // Handshake: a request is taken only in IDLE when req_valid and an op bit are
   // high; stall holds the upstream stages until the DONE cycle lets them advance.
   assign req_any   = req_valid & (req_read | req_write);
   assign req_mis   = req_addr[1:0] != 2'b00;
   assign req_oob   = {2'b00, req_addr[31:2]} >= 32'(ADDR_WORDS);
   assign req_ok    = req_any & ~req_mis & ~req_oob;
   assign stall     = rst & ((state == ACCESS) | ((state == IDLE) & req_ok));
   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         count      <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         misalign   <= 1'b0;
         oob        <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_any) begin
                  if (req_mis || req_oob) begin
                     resp_valid <= 1'b1;
                     resp_rdata <= '0;
                     misalign   <= req_mis;
                     oob        <= ~req_mis & req_oob;
                     state      <= ERR;
                  end else begin
                     // A store wins when both op bits are set.
                     mem_addr  <= {2'b00, req_addr[31:2]};
                     mem_wdata <= req_wdata;
                     mem_write <= req_write;
                     mem_read  <= ~req_write;
                     count     <= CNT_INIT;
                     state     <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (count == 4'd0) begin
                  resp_rdata <= mem_read ? mem_rdata : 32'd0;
                  resp_valid <= 1'b1;
                  mem_read   <= 1'b0;
                  mem_write  <= 1'b0;
                  state      <= DONE;
               end else begin
                  count <= count - 4'd1;
               end
            end
            DONE: begin
               resp_valid <= 1'b0;
               state      <= IDLE;
            end
            ERR: begin
               resp_valid <= 1'b0;
               misalign   <= 1'b0;
               oob        <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (latency 2 and 1) with behavioural
// data memories, checked cycle by cycle against a reference model.
module tb_mem_access_ctrl;

   logic        clk;
   logic        rst;
   logic        req_valid0, req_valid1;
   logic        req_read, req_write;
   logic [31:0] req_addr, req_wdata;

   logic        stall0, resp_valid0, misalign0, oob0, mem_read0, mem_write0;
   logic [31:0] resp_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
   logic [1:0]  dbg_state0;
   logic        stall1, resp_valid1, misalign1, oob1, mem_read1, mem_write1;
   logic [31:0] resp_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
   logic [1:0]  dbg_state1;

   logic [31:0] mem0 [256];
   logic [31:0] mem1 [256];
   logic        bd_we;
   logic [7:0]  bd_addr;
   logic [31:0] bd_data;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        stall, mrd, mwr, rv, mis, oob;
      logic [31:0] maddr, mwdata, rdata;
   } obs_t;

   int          lat [2] = '{2, 1};
   logic [31:0] ref_mem [2][256];
   logic [31:0] last_maddr [2];
   logic [31:0] last_mwdata [2];
   logic [31:0] last_rdata [2];

   mem_access_ctrl #(.MEM_LATENCY(2), .ADDR_WORDS(256)) dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid0), .req_read(req_read),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall0), .resp_valid(resp_valid0), .resp_rdata(resp_rdata0),
      .misalign(misalign0), .oob(oob0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
      .mem_read(mem_read0), .mem_write(mem_write0), .mem_rdata(mem_rdata0),
      .dbg_state(dbg_state0));

   mem_access_ctrl #(.MEM_LATENCY(1), .ADDR_WORDS(256)) dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid1), .req_read(req_read),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall1), .resp_valid(resp_valid1), .resp_rdata(resp_rdata1),
      .misalign(misalign1), .oob(oob1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_read(mem_read1), .mem_write(mem_write1), .mem_rdata(mem_rdata1),
      .dbg_state(dbg_state1));

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // data memories with a bench-side preload port
   assign mem_rdata0 = mem0[mem_addr0[7:0]];
   assign mem_rdata1 = mem1[mem_addr1[7:0]];
   always @(posedge clk) begin
      if (bd_we) begin
         mem0[bd_addr] <= bd_data;
         mem1[bd_addr] <= bd_data;
      end else begin
         if (mem_write0) mem0[mem_addr0[7:0]] <= mem_wdata0;
         if (mem_write1) mem1[mem_addr1[7:0]] <= mem_wdata1;
      end
   end

   function automatic obs_t get_obs(input int sel);
      obs_t o;
      if (sel == 0)
         o = '{stall0, mem_read0, mem_write0, resp_valid0, misalign0, oob0,
               mem_addr0, mem_wdata0, resp_rdata0};
      else
         o = '{stall1, mem_read1, mem_write1, resp_valid1, misalign1, oob1,
               mem_addr1, mem_wdata1, resp_rdata1};
      return o;
   endfunction

   task automatic preload(input int idx, input logic [31:0] data);
      @(negedge clk);
      bd_we = 1'b1; bd_addr = 8'(idx); bd_data = data;
      @(negedge clk);
      bd_we = 1'b0;
      ref_mem[0][idx] = data;
      ref_mem[1][idx] = data;
   endtask

   task automatic scramble_inputs(input int sel);
      if (sel == 0) req_valid0 = 1'($urandom); else req_valid1 = 1'($urandom);
      req_read  = 1'($urandom);
      req_write = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
   endtask

   // One instruction through the memory stage, checked on every cycle it occupies.
   task automatic do_req(input int sel, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [31:0] wd);
      obs_t o, e;
      bit mis, oob_e, legal, st;
      int idx, l;
      l     = lat[sel];
      idx   = int'(addr >> 2);
      mis   = (addr % 4) != 0;
      oob_e = !mis && (addr / 4) >= 256;
      st    = wr;
      legal = (rd || wr) && !mis && !oob_e;

      @(negedge clk);
      req_valid0 = (sel == 0); req_valid1 = (sel == 1);
      req_read = rd; req_write = wr; req_addr = addr; req_wdata = wd;
      #1;
      o = get_obs(sel);
      e = '{legal, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, last_maddr[sel], last_mwdata[sel], last_rdata[sel]};
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL req_cycle0 sel=%0d addr=%h got %h exp %h", sel, addr, o, e);
      end

      if (legal) begin
         for (int k = 1; k <= l + 1; k++) begin
            @(negedge clk);
            scramble_inputs(sel);
            #1;
            o = get_obs(sel);
            if (k <= l)
               e = '{1'b1, !st, st, 1'b0, 1'b0, 1'b0, 32'(idx), wd, last_rdata[sel]};
            else
               e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'(idx), wd,
                     st ? 32'd0 : ref_mem[sel][idx]};
            checks++;
            if (o !== e) begin
               errors++;
               $display("FAIL access_cycle%0d sel=%0d addr=%h st=%0d got %h exp %h",
                        k, sel, addr, st, o, e);
            end
         end
         if (st) ref_mem[sel][idx] = wd;
         last_maddr[sel]  = 32'(idx);
         last_mwdata[sel] = wd;
         last_rdata[sel]  = st ? 32'd0 : ref_mem[sel][idx];
      end else begin
         @(negedge clk);
         if (rd || wr) scramble_inputs(sel);
         #1;
         o = get_obs(sel);
         if (rd || wr) begin
            e = '{1'b0, 1'b0, 1'b0, 1'b1, mis, oob_e, last_maddr[sel], last_mwdata[sel], 32'd0};
            last_rdata[sel] = 32'd0;
         end else begin
            e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, last_maddr[sel], last_mwdata[sel], last_rdata[sel]};
         end
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL error_resp sel=%0d addr=%h got %h exp %h", sel, addr, o, e);
         end
      end
   endtask

   task automatic test_reset;
      obs_t o;
      rst = 1'b0;
      req_valid0 = 1'b1; req_valid1 = 1'b1;
      req_read = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_wdata = 32'h5;
      bd_we = 1'b0; bd_addr = '0; bd_data = '0;
      for (int i = 0; i < 256; i++) begin
         logic [31:0] v;
         v = $urandom;
         mem0[i] = v; mem1[i] = v;
         ref_mem[0][i] = v; ref_mem[1][i] = v;
      end
      repeat (2) @(negedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         o = get_obs(s);
         checks++;
         if (o !== '0) begin
            errors++;
            $display("FAIL reset_outputs sel=%0d got %h exp 0", s, o);
         end
         last_maddr[s] = '0; last_mwdata[s] = '0; last_rdata[s] = '0;
      end
      req_valid0 = 1'b0; req_valid1 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_load;
      preload(5, 32'hCAFE0001);
      do_req(0, 1'b1, 1'b0, 32'h14, 32'h0);
   endtask

   task automatic test_store_load;
      do_req(0, 1'b0, 1'b1, 32'h20, 32'h12345678);
      do_req(0, 1'b1, 1'b0, 32'h20, 32'h0);
   endtask

   task automatic test_errors;
      do_req(0, 1'b1, 1'b0, 32'h13, 32'h0);
      do_req(0, 1'b1, 1'b0, 32'h400, 32'h0);
      do_req(0, 1'b1, 1'b0, 32'h401, 32'h0);
      do_req(0, 1'b0, 1'b1, 32'h3FC, 32'hA5A5A5A5);
      do_req(0, 1'b0, 1'b0, 32'h24, 32'h0);
   endtask

   task automatic test_read_write_both;
      do_req(0, 1'b1, 1'b1, 32'h8, 32'hDEADBEEF);
      do_req(0, 1'b1, 1'b0, 32'h8, 32'h0);
   endtask

   task automatic test_reset_mid_store;
      obs_t o;
      @(negedge clk);
      req_valid0 = 1'b1; req_valid1 = 1'b0;
      req_read = 1'b0; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'h0BADF00D;
      @(negedge clk);
      req_valid0 = 1'b0;
      #1;
      checks++;
      if ({stall0, mem_write0} !== 2'b11) begin
         errors++;
         $display("FAIL store_before_reset got %b exp 11", {stall0, mem_write0});
      end
      rst = 1'b0;
      #1;
      for (int s = 0; s < 2; s++) begin
         o = get_obs(s);
         checks++;
         if (o !== '0) begin
            errors++;
            $display("FAIL async_reset sel=%0d got %h exp 0", s, o);
         end
         last_maddr[s] = '0; last_mwdata[s] = '0; last_rdata[s] = '0;
      end
      @(negedge clk);
      rst = 1'b1;
      do_req(0, 1'b1, 1'b0, 32'h40, 32'h0);
      do_req(0, 1'b0, 1'b1, 32'h40, 32'h13572468);
      do_req(0, 1'b1, 1'b0, 32'h40, 32'h0);
   endtask

   task automatic test_back_to_back;
      do_req(1, 1'b0, 1'b1, 32'h30, 32'hFEEDFACE);
      for (int i = 0; i < 8; i++)
         do_req(1, 1'b1, 1'b0, 32'($urandom_range(0, 255)) * 4, $urandom);
      do_req(1, 1'b1, 1'b0, 32'h30, 32'h0);
   endtask

   task automatic test_random;
      for (int i = 0; i < 40; i++) begin
         int op;
         logic [31:0] addr;
         op = $urandom_range(0, 3);
         if ($urandom_range(0, 9) == 0)
            addr = $urandom;
         else
            addr = 32'($urandom_range(0, 270)) * 4 +
                   (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
         do_req(0, op[0], op[1], addr, $urandom);
      end
   endtask

   initial begin
      test_reset;
      test_load;
      test_store_load;
      test_errors;
      test_read_write_both;
      test_reset_mid_store;
      test_back_to_back;
      test_random;
      @(negedge clk);
      req_valid0 = 1'b0; req_valid1 = 1'b0;
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage sequencer between the EX/MEM latch and the data memory.
- Accepts one load/store request per instruction and converts the byte address to a word index.
- Drives memread/memwrite/addr/write_data to the data memory for a fixed, parameterised number of cycles, and stalls the pipeline while the access is in flight.
- Returns load data and status to the MEM/WB latch.

Parameters:
MEM_LATENCY, 2, cycles the memory controls are held per access (legal range 1..15).
ADDR_WORDS, 256, number of 32-bit words in data memory; word indices at or above this are out of range.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
req_valid  input  1  EX/MEM holds a memory instruction.
req_read  input  1  load request (EX/MEM memread).
req_write  input  1  store request (EX/MEM memwrite).
req_addr  input  32  byte address (ALU result).
req_wdata  input  32  store data (rdata2out).
stall  output  1  freeze PC, IF/ID, ID/EX and EX/MEM.
resp_valid  output  1  one-cycle pulse: access finished; MEM/WB captures.
resp_rdata  output  32  load data; 0 for stores and errors.
misalign  output  1  pulses with resp_valid when req_addr[1:0] != 0.
oob  output  1  pulses with resp_valid when req_addr[31:2] >= ADDR_WORDS.
mem_addr  output  32  word index to data memory (zero-extended req_addr[31:2]).
mem_wdata  output  32  write data to data memory.
mem_read  output  1  data memory memread.
mem_write  output  1  data memory memwrite.
mem_rdata  input  32  data memory read_data.

Behaviour:
Reset:
- rst low forces, immediately and asynchronously, state IDLE, count 0, and every output 0, including mem_addr and mem_wdata.
- An in-flight store is abandoned: mem_write drops without waiting for a clock edge.

Request classification (IDLE only):
- A request is valid when req_valid=1 and (req_read | req_write).
- Both req_read and req_write high: store; the read is ignored.
- Misaligned takes precedence over out-of-range; misalign and oob are never high together.

State machine (IDLE, ACCESS, DONE, ERR):
- IDLE, no valid request: stall=0, mem_read=mem_write=0; stay in IDLE.
- IDLE, legal valid request:
  - stall=1 combinationally in the same cycle.
  - At the edge: latch mem_addr={2'b0,req_addr[31:2]}, mem_wdata=req_wdata and the op; count=MEM_LATENCY-1; go to ACCESS.
- IDLE, misaligned or out-of-range: stall=0; at the edge go to ERR. No memory control is asserted.
- ACCESS: stall=1.
  - mem_read (load) or mem_write (store) held high.
  - mem_addr and mem_wdata held stable.
  - count decrements each cycle. At count==0:
    - resp_rdata<=mem_rdata (load) or 0 (store).
    - Controls drop at the edge.
    - Go to DONE.
- DONE: resp_valid=1, stall=0, no new request accepted; next state IDLE. The pipeline advances at this edge.
- ERR: resp_valid=1, misalign or oob=1, resp_rdata=0, stall=0; next state IDLE.

Timing and output rules:
- Latency: request seen at cycle 0; ACCESS occupies cycles 1..MEM_LATENCY; resp_valid at cycle MEM_LATENCY+1; stall high on cycles 0..MEM_LATENCY.
- Back-to-back requests: one bubble-free IDLE cycle separates them. Throughput is one access per MEM_LATENCY+2 cycles.
- resp_valid, misalign and oob are registered single-cycle pulses.
- resp_rdata holds its value until the next response.
- mem_addr and mem_wdata keep their last values outside ACCESS.
- req_* changing during ACCESS is ignored; all operands are taken from the IDLE-cycle capture.

Test Plan:
- Load, MEM_LATENCY=2, DMEM[5]=0xCAFE0001, req_addr=0x14 -> mem_addr=5, mem_read high on cycles 1-2, stall high on cycles 0-2, resp_valid with resp_rdata=0xCAFE0001 on cycle 3.
- Store req_addr=0x20, req_wdata=0x12345678, then load from 0x20 -> mem_write high 2 cycles at mem_addr=8; subsequent load returns 0x12345678; store response has resp_rdata=0.
- Misaligned load req_addr=0x13 -> misalign=1, resp_valid=1, resp_rdata=0 on cycle 1; mem_read never asserts; stall never asserts.
- Out-of-range req_addr=0x400 (word 256) -> oob pulse on cycle 1; req_addr=0x401 -> misalign only.
- rst asserted low in the first ACCESS cycle of a store -> mem_write, stall and all outputs 0 immediately; after release, state is IDLE and the next request completes normally.
- req_read=req_write=1 at 0x8, and MEM_LATENCY=1 back-to-back loads -> treated as a store; each load gives resp_valid every 3 cycles with correct data.
